param_sdp_ram: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port and one read port in a single clock domain. It extends the team's 8-bit x 64 single-port RAM with configurable width and depth, per-byte write enables, selectable read latency, and a defined read-during-write policy. It also has a read-valid strobe and a built-in clear sequencer that zero-fills the array after power-up. It is the common storage primitive for buffers and lookup tables in the datapath.

---
 rtl/param_sdp_ram.sv | 152 +++++++++++++++
 tb/tb_param_sdp_ram.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sdp_ram.sv
// Simple-dual-port synchronous RAM: byte-enabled write port, 1- or 2-cycle read
// port, selectable read-during-write policy and a zero-fill clear sequencer.
module param_sdp_ram #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  acc_err,
  output logic [1:0]            dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;
  logic              clr_done_q;
  logic              acc_err_q;

  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_word_d;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // External accesses are simply dropped while the clear sequencer owns the array.
  assign wr_fire = wr_en & ~busy_q;
  assign rd_fire = rd_en & ~busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      acc_err_q  <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      acc_err_q  <= busy_q & (wr_en | rd_en);
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; contents survive rst and only the clear sequence zeroes them.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_old = mem[rd_addr];

  // Write-first merges the enabled bytes of a same-address write into the read word.
  always_comb begin
    rd_word_d = rd_old;
    if (RDW_MODE != 0 && wr_fire && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word_d[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s1_valid_q;
      logic [DATA_W-1:0] s1_data_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_fire;
          if (rd_fire) s1_data_q <= rd_word_d;
        end
      end
      assign out_valid_d = s1_valid_q;
      assign out_data_d  = s1_data_q;
    end else begin : g_lat1
      assign out_valid_d = rd_fire;
      assign out_data_d  = rd_word_d;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= out_valid_d;
      if (out_valid_d) rd_data_q <= out_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign clr_done  = clr_done_q;
  assign acc_err   = acc_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_sdp_ram.sv
// Directed bench for param_sdp_ram: three instances (read-first, write-first,
// two-cycle latency) share one stimulus bus and are checked against hand values.
module tb_param_sdp_ram;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          clr_req;

  logic [DW-1:0] rf_data, wf_data, l2_data;
  logic          rf_valid, wf_valid, l2_valid;
  logic          rf_busy, wf_busy, l2_busy;
  logic          rf_done, wf_done, l2_done;
  logic          rf_err, wf_err, l2_err;
  logic [1:0]    rf_st, wf_st, l2_st;

  int checks;
  int failures;

  param_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .RDW_MODE(0)) u_rf (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rf_data),
    .rd_valid(rf_valid), .clr_req(clr_req), .busy(rf_busy), .clr_done(rf_done),
    .acc_err(rf_err), .dbg_state(rf_st));

  param_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .RDW_MODE(1)) u_wf (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(wf_data),
    .rd_valid(wf_valid), .clr_req(clr_req), .busy(wf_busy), .clr_done(wf_done),
    .acc_err(wf_err), .dbg_state(wf_st));

  param_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .RDW_MODE(0)) u_l2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(l2_data),
    .rd_valid(l2_valid), .clr_req(clr_req), .busy(l2_busy), .clr_done(l2_done),
    .acc_err(l2_err), .dbg_state(l2_st));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++; if (rf_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rf_data); end
    checks++; if (rf_valid !== 1'b0 || l2_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b/%b exp=0", rf_valid, l2_valid); end
    checks++; if (rf_busy !== 1'b0 || rf_done !== 1'b0 || rf_err !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b err=%b exp=0", rf_busy, rf_done, rf_err); end
    checks++; if (rf_st !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", rf_st); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    drive_write(4'd3, 32'hDEADBEEF, 4'hF);
    tick();
    wr_en = 1'b0;
    drive_read(4'd3);
    tick();
    rd_en = 1'b0;
    checks++; if (rf_data !== 32'hDEADBEEF || rf_valid !== 1'b1) begin failures++; $display("FAIL wr_rd_lat1 got=%h v=%b exp=deadbeef v=1", rf_data, rf_valid); end
    checks++; if (l2_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_lat2_early got v=%b exp=0", l2_valid); end
    tick();
    checks++; if (rf_valid !== 1'b0 || rf_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_hold got=%h v=%b exp=deadbeef v=0", rf_data, rf_valid); end
    checks++; if (l2_data !== 32'hDEADBEEF || l2_valid !== 1'b1) begin failures++; $display("FAIL wr_rd_lat2 got=%h v=%b exp=deadbeef v=1", l2_data, l2_valid); end
    tick();
    checks++; if (l2_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_lat2_pulse got v=%b exp=0", l2_valid); end
  endtask

  task automatic test_byte_enables();
    drive_write(4'd3, 32'h11223344, 4'b0101);
    tick();
    wr_en = 1'b0;
    drive_read(4'd3);
    tick();
    rd_en = 1'b0;
    checks++; if (rf_data !== 32'hDE22BE44) begin failures++; $display("FAIL byte_en_rf got=%h exp=de22be44", rf_data); end
    checks++; if (wf_data !== 32'hDE22BE44) begin failures++; $display("FAIL byte_en_wf got=%h exp=de22be44", wf_data); end
    drive_write(4'd3, 32'h99999999, 4'b0000);
    tick();
    wr_en = 1'b0;
    drive_read(4'd3);
    tick();
    rd_en = 1'b0;
    checks++; if (rf_data !== 32'hDE22BE44) begin failures++; $display("FAIL byte_en_zero got=%h exp=de22be44", rf_data); end
    tick();
  endtask

  task automatic test_reset_pending();
    drive_read(4'd3);
    tick();
    rd_en = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (rf_data !== 32'h0 || rf_valid !== 1'b0) begin failures++; $display("FAIL rst_async_rf got=%h v=%b exp=0 v=0", rf_data, rf_valid); end
    checks++; if (l2_data !== 32'h0 || l2_valid !== 1'b0 || l2_busy !== 1'b0) begin failures++; $display("FAIL rst_async_l2 got=%h v=%b b=%b exp=0", l2_data, l2_valid, l2_busy); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (l2_valid !== 1'b0 || rf_valid !== 1'b0) begin failures++; $display("FAIL rst_no_pulse cyc=%0d got=%b/%b exp=0", i, l2_valid, rf_valid); end
    end
  endtask

  task automatic test_collision();
    drive_write(4'd5, 32'hAAAA5555, 4'hF);
    tick();
    drive_write(4'd5, 32'h12345678, 4'hF);
    drive_read(4'd5);
    tick();
    checks++; if (rf_data !== 32'hAAAA5555) begin failures++; $display("FAIL rdw_read_first got=%h exp=aaaa5555", rf_data); end
    checks++; if (wf_data !== 32'h12345678) begin failures++; $display("FAIL rdw_write_first got=%h exp=12345678", wf_data); end
    drive_write(4'd5, 32'hCAFEBABE, 4'b1100);
    drive_read(4'd5);
    tick();
    checks++; if (rf_data !== 32'h12345678) begin failures++; $display("FAIL rdw_partial_rf got=%h exp=12345678", rf_data); end
    checks++; if (wf_data !== 32'hCAFE5678) begin failures++; $display("FAIL rdw_partial_wf got=%h exp=cafe5678", wf_data); end
    drive_write(4'd6, 32'hFFFFFFFF, 4'hF);
    drive_read(4'd3);
    tick();
    idle_inputs();
    checks++; if (rf_data !== 32'hDE22BE44 || wf_data !== 32'hDE22BE44) begin failures++; $display("FAIL rdw_diff_addr got=%h/%h exp=de22be44", rf_data, wf_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_read(4'd3);
    tick();
    checks++; if (l2_valid !== 1'b0) begin failures++; $display("FAIL b2b_first_early got v=%b exp=0", l2_valid); end
    drive_read(4'd5);
    tick();
    rd_en = 1'b0;
    checks++; if (l2_valid !== 1'b1 || l2_data !== 32'hDE22BE44) begin failures++; $display("FAIL b2b_first got=%h v=%b exp=de22be44 v=1", l2_data, l2_valid); end
    tick();
    checks++; if (l2_valid !== 1'b1 || l2_data !== 32'hCAFE5678) begin failures++; $display("FAIL b2b_second got=%h v=%b exp=cafe5678 v=1", l2_data, l2_valid); end
    tick();
    checks++; if (l2_valid !== 1'b0 || l2_data !== 32'hCAFE5678) begin failures++; $display("FAIL b2b_hold got=%h v=%b exp=cafe5678 v=0", l2_data, l2_valid); end
  endtask

  task automatic test_clear();
    int n;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checks++; if (rf_busy !== 1'b1 || rf_st !== 2'd1) begin failures++; $display("FAIL clr_start got busy=%b st=%0d exp=1/1", rf_busy, rf_st); end
    n = 0;
    while (rf_busy === 1'b1 && n < 40) begin
      n++;
      idle_inputs();
      if (n == 3) begin
        drive_write(4'd0, 32'hFFFFFFFF, 4'hF);
        drive_read(4'd3);
      end
      if (n == 5) clr_req = 1'b1;
      tick();
      if (n == 3) begin
        checks++; if (rf_err !== 1'b1) begin failures++; $display("FAIL clr_acc_err got=%b exp=1", rf_err); end
        checks++; if (rf_valid !== 1'b0) begin failures++; $display("FAIL clr_rd_dropped got v=%b exp=0", rf_valid); end
      end
      if (n == 4) begin
        checks++; if (rf_err !== 1'b0 || l2_valid !== 1'b0) begin failures++; $display("FAIL clr_err_pulse got err=%b l2v=%b exp=0", rf_err, l2_valid); end
      end
    end
    idle_inputs();
    checks++; if (n != 16) begin failures++; $display("FAIL clr_busy_len got=%0d exp=16", n); end
    checks++; if (rf_done !== 1'b1 || rf_busy !== 1'b0) begin failures++; $display("FAIL clr_done got done=%b busy=%b exp=1/0", rf_done, rf_busy); end
    tick();
    checks++; if (rf_done !== 1'b0 || rf_st !== 2'd0) begin failures++; $display("FAIL clr_done_pulse got done=%b st=%0d exp=0/0", rf_done, rf_st); end
    for (int a = 0; a < 16; a++) begin
      drive_read(a[AW-1:0]);
      tick();
      checks++; if (rf_data !== 32'h0 || rf_valid !== 1'b1) begin failures++; $display("FAIL clr_zero addr=%0d got=%h v=%b exp=0 v=1", a, rf_data, rf_valid); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_clear();
    drive_write(4'd10, 32'h5A5A5A5A, 4'hF);
    tick();
    drive_write(4'd2, 32'h13572468, 4'hF);
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    checks++; if (rf_busy !== 1'b0 || rf_st !== 2'd0) begin failures++; $display("FAIL midclr_rst got busy=%b st=%0d exp=0/0", rf_busy, rf_st); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst = 1'b1;
      tick();
      checks++; if (rf_done !== 1'b0 || rf_busy !== 1'b0) begin failures++; $display("FAIL midclr_no_done cyc=%0d got done=%b busy=%b exp=0", i, rf_done, rf_busy); end
    end
    drive_read(4'd10);
    tick();
    checks++; if (rf_data !== 32'h5A5A5A5A) begin failures++; $display("FAIL midclr_keep got=%h exp=5a5a5a5a", rf_data); end
    drive_read(4'd2);
    tick();
    idle_inputs();
    checks++; if (rf_data !== 32'h0) begin failures++; $display("FAIL midclr_cleared got=%h exp=0", rf_data); end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_byte_enables();
    test_reset_pending();
    test_collision();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
